// File: rtl/branch_predictor_if.sv
// Lookup and training bus between the fetch/execute stages and the branch predictor.
// The master side drives PCs and resolved outcomes; the predictor (slave) returns the prediction.
interface branch_predictor_if;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        btb_hit;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
    input  pred_taken, pred_target, btb_hit
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
    output pred_taken, pred_target, btb_hit
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational lookup, synchronous training.
// Define GSHARE_EN to move the counters into a separate PHT indexed by idx ^ global history.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int PC_TOP  = IDX_BITS + TAG_BITS + 1;

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  idx_t lk_idx;
  idx_t up_idx;
  tag_t lk_tag;
  tag_t up_tag;
  logic lk_hit;
  logic up_hit;
  logic lk_dir;
  logic unused_pc_bits;

  logic [ENTRIES-1:0] valid_q, valid_d;
  tag_t               tag_q    [ENTRIES];
  tag_t               tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign lk_idx = bp.lookup_pc[IDX_BITS+1:2];
  assign lk_tag = bp.lookup_pc[PC_TOP:IDX_BITS+2];
  assign up_idx = bp.upd_pc[IDX_BITS+1:2];
  assign up_tag = bp.upd_pc[PC_TOP:IDX_BITS+2];

  assign unused_pc_bits = ^{bp.lookup_pc[31:PC_TOP+1], bp.lookup_pc[1:0],
                            bp.upd_pc[31:PC_TOP+1], bp.upd_pc[1:0]};

  // Gating with rst keeps the outputs at zero while reset is held, before the arrays clear.
  assign lk_hit = !rst && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign bp.btb_hit     = lk_hit;
  assign bp.pred_taken  = lk_hit && lk_dir;
  assign bp.pred_target = (lk_hit && lk_dir) ? target_q[lk_idx] : 32'h0;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bp.upd_valid) begin
      if (up_hit) begin
        if (bp.upd_taken) target_d[up_idx] = bp.upd_target;
      end else if (bp.upd_taken) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = bp.upd_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tags and targets are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef GSHARE_EN
  logic [1:0] pht_q [ENTRIES];
  logic [1:0] pht_d [ENTRIES];
  idx_t       ghr_q, ghr_d;

  // The PHT trains on every resolved branch using the history from before this shift.
  always_comb begin
    pht_d = pht_q;
    ghr_d = ghr_q;
    if (bp.upd_valid) begin
      pht_d[up_idx ^ ghr_q] = ctr_step(pht_q[up_idx ^ ghr_q], bp.upd_taken);
      ghr_d = {ghr_q[IDX_BITS-2:0], bp.upd_taken};
    end
  end

  assign lk_dir = pht_q[lk_idx ^ ghr_q][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
    end else begin
      ghr_q <= ghr_d;
      pht_q <= pht_d;
    end
  end
`else
  logic [1:0] ctr_q [ENTRIES];
  logic [1:0] ctr_d [ENTRIES];

  // A fresh allocation starts weakly taken; a miss that was not taken leaves the entry alone.
  always_comb begin
    ctr_d = ctr_q;
    if (bp.upd_valid) begin
      if (up_hit)              ctr_d[up_idx] = ctr_step(ctr_q[up_idx], bp.upd_taken);
      else if (bp.upd_taken)   ctr_d[up_idx] = 2'b10;
    end
  end

  assign lk_dir = ctr_q[lk_idx][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else begin
      ctr_q <= ctr_d;
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, reset sequences and
// randomized traffic compared against an array-based reference model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  branch_predictor_if bp_bus ();

  branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  // Reference model: one slot per index, counters kept as plain integers 0..3.
  bit          m_valid  [64];
  int          m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  int          m_pht    [64];
  int          m_ghr;

  function automatic int pcIdx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic int pcTag(input logic [31:0] pc);
    return int'((pc >> 8) % 256);
  endfunction

  function automatic int bump(input int c, input logic taken);
    if (taken) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
      m_pht[i]   = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic void modelPredict(input logic [31:0] pc, output logic hit,
                                       output logic taken, output logic [31:0] tgt);
    int i;
    int dir;
    i   = pcIdx(pc);
    hit = m_valid[i] && (m_tag[i] == pcTag(pc));
`ifdef GSHARE_EN
    dir = m_pht[i ^ m_ghr];
`else
    dir = m_ctr[i];
`endif
    taken = hit && (dir >= 2);
    tgt   = taken ? m_target[i] : 32'h0;
  endfunction

  function automatic void modelUpdate(input logic [31:0] pc, input logic taken,
                                      input logic [31:0] tgt);
    int  i;
    bit  hit;
    i   = pcIdx(pc);
    hit = m_valid[i] && (m_tag[i] == pcTag(pc));
`ifdef GSHARE_EN
    m_pht[i ^ m_ghr] = bump(m_pht[i ^ m_ghr], taken);
    m_ghr = ((m_ghr * 2) + int'(taken)) % 64;
`else
    if (hit) m_ctr[i] = bump(m_ctr[i], taken);
    else if (taken) m_ctr[i] = 2;
`endif
    if (hit) begin
      if (taken) m_target[i] = tgt;
    end else if (taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = pcTag(pc);
      m_target[i] = tgt;
    end
  endfunction

  function automatic logic [31:0] mkPc();
    logic [31:0] pc;
    pc = ($urandom_range(0, 3) << 16) | ($urandom_range(0, 3) << 8) |
         ($urandom_range(0, 3) << 2)  |  $urandom_range(0, 3);
    return pc;
  endfunction

  // Drives one cycle's inputs just after the falling edge, then lets the lookup settle.
  task automatic applyStimulus(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic r);
    @(negedge clk);
    rst                  = r;
    bp_bus.lookup_pc     = lpc;
    bp_bus.upd_valid     = uv;
    bp_bus.upd_pc        = upc;
    bp_bus.upd_taken     = ut;
    bp_bus.upd_target    = utgt;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic e_hit, input logic e_taken,
                             input logic [31:0] e_tgt);
    checks++;
    if (bp_bus.btb_hit !== e_hit) begin
      errors++;
      $display("[TB] FAIL %s.hit: got %b, expected %b", name, bp_bus.btb_hit, e_hit);
    end
    checks++;
    if (bp_bus.pred_taken !== e_taken) begin
      errors++;
      $display("[TB] FAIL %s.taken: got %b, expected %b", name, bp_bus.pred_taken, e_taken);
    end
    checks++;
    if (bp_bus.pred_target !== e_tgt) begin
      errors++;
      $display("[TB] FAIL %s.target: got %h, expected %h", name, bp_bus.pred_target, e_tgt);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [20];
    logic        r;
    logic        uv;
    logic        ut;
    logic [31:0] lpc;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;

    // Each row is one cycle; expectations are the lookup result before that cycle's edge.
    vecs[0]  = '{32'h100,   1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{32'h100,   1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
    vecs[2]  = '{32'h100,   1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0};
    vecs[3]  = '{32'h100,   1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{32'h100,   1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0};
    vecs[5]  = '{32'h100,   1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
    vecs[6]  = '{32'h100,   1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200};
    vecs[7]  = '{32'h100,   1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
    vecs[8]  = '{32'h100,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h200};
    vecs[9]  = '{32'h100,   1'b1, 32'h100, 1'b1, 32'h240, 1'b1, 1'b1, 32'h200};
    vecs[10] = '{32'h100,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h240};
    vecs[11] = '{32'h200,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[12] = '{32'h200,   1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[13] = '{32'h100,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h240};
    vecs[14] = '{32'h200,   1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0};
    vecs[15] = '{32'h100,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0};
    vecs[16] = '{32'h200,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h300};
    vecs[17] = '{32'h140,   1'b1, 32'h140, 1'b1, 32'h180, 1'b0, 1'b0, 32'h0};
    vecs[18] = '{32'h140,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h180};
    vecs[19] = '{32'h10142, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h180};

    bp_bus.lookup_pc  = 32'h0;
    bp_bus.upd_valid  = 1'b0;
    bp_bus.upd_pc     = 32'h0;
    bp_bus.upd_taken  = 1'b0;
    bp_bus.upd_target = 32'h0;

    // Training attempted while reset is held must be ignored.
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_hold0", 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    checkOutput("rst_hold1", 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("post_rst", 1'b0, 1'b0, 32'h0);

`ifndef GSHARE_EN
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].lookup_pc, vecs[i].upd_valid, vecs[i].upd_pc,
                    vecs[i].upd_taken, vecs[i].upd_target, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_taken,
                  vecs[i].exp_target);
    end
`else
    // Allocation shifts history to 1, so the lookup reads an untouched PHT slot.
    applyStimulus(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    checkOutput("gs_alloc", 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("gs_lookup", 1'b1, 1'b0, 32'h0);
    applyStimulus(32'h140, 1'b1, 32'h140, 1'b1, 32'h180, 1'b0);
    checkOutput("gs_alloc2", 1'b0, 1'b0, 32'h0);
`endif

    // Mid-stream reset discards all trained entries.
    applyStimulus(32'h140, 1'b1, 32'h140, 1'b1, 32'h180, 1'b1);
    checkOutput("mid_rst", 1'b0, 1'b0, 32'h0);
    applyStimulus(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("after_mid_rst", 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    modelReset();

    for (int n = 0; n < 600; n++) begin
      r    = ($urandom_range(0, 49) == 0);
      lpc  = mkPc();
      uv   = ($urandom_range(0, 9) < 7);
      upc  = (n % 3 == 0) ? lpc : mkPc();
      ut   = $urandom_range(0, 1) == 1;
      utgt = $urandom;
      applyStimulus(lpc, uv, upc, ut, utgt, r);
      if (r) begin
        e_hit   = 1'b0;
        e_taken = 1'b0;
        e_tgt   = 32'h0;
      end else begin
        modelPredict(lpc, e_hit, e_taken, e_tgt);
      end
      checkOutput($sformatf("rand%0d", n), e_hit, e_taken, e_tgt);
      @(posedge clk);
      if (r) modelReset();
      else if (uv) modelUpdate(upc, ut, utgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
